// File: rtl/muldiv_sched_if.sv
// Bundle between EX decode, the sequencer and the mul/div units.
// The sequencer uses the master view; the EX side plus units use the slave view.
interface muldiv_sched_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        pipe_hold;
    logic        flush;
    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stallreq;
    logic        res_valid;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic [31:0] gpr_result;
    logic        busy;

    modport master (
        input  op_valid, op_code, op_a, op_b, pipe_hold, flush,
        input  mul_result, div_result, div_ready,
        output mul_signed, mul_ina, mul_inb,
        output div_start, div_signed, div_op1, div_op2, div_annul,
        output stallreq, res_valid, hi_we, lo_we, hi_wdata, lo_wdata, gpr_result, busy
    );

    modport slave (
        output op_valid, op_code, op_a, op_b, pipe_hold, flush,
        output mul_result, div_result, div_ready,
        input  mul_signed, mul_ina, mul_inb,
        input  div_start, div_signed, div_op1, div_op2, div_annul,
        input  stallreq, res_valid, hi_we, lo_we, hi_wdata, lo_wdata, gpr_result, busy
    );
endinterface

// File: rtl/muldiv_sched.sv
// EX-stage mul/div sequencer: latches one op, drives the mul/div units, stalls EX,
// and issues a single HI/LO (or GPR) write when the result is complete.
module muldiv_sched #(
    parameter int unsigned MUL_LAT = 2
) (
    input logic            clk,
    input logic            rst,
    muldiv_sched_if.master bus
);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned DW    = 32;

    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MUL   = OP_W'(5);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [OP_W-1:0]  op_q;
    logic [DW-1:0]    a_q, b_q, hi_q, lo_q;

    logic is_mul_in, is_div_in, div_zero, accept;
    logic stallreq, div_start, div_annul, hi_we, lo_we;

    assign is_mul_in = (bus.op_code == OP_MULT) || (bus.op_code == OP_MULTU) || (bus.op_code == OP_MUL);
    assign is_div_in = (bus.op_code == OP_DIV) || (bus.op_code == OP_DIVU);
    assign div_zero  = (bus.op_b == '0);
    assign accept    = (state_q == IDLE) && bus.op_valid && (is_mul_in || is_div_in) && !bus.flush;

    // Next state and handshake strobes; flush overrides everything at the end.
    always_comb begin
        state_d   = state_q;
        stallreq  = 1'b0;
        div_start = 1'b0;
        div_annul = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stallreq = 1'b1;
                    if (is_mul_in)     state_d = MUL_WAIT;
                    else if (div_zero) state_d = DONE;
                    else               state_d = DIV_BUSY;
                end
            end
            MUL_WAIT: begin
                stallreq = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DIV_BUSY: begin
                stallreq  = 1'b1;
                div_start = !bus.div_ready;
                if (bus.div_ready) state_d = DONE;
            end
            DONE: begin
                if (!bus.pipe_hold) begin
                    hi_we   = (op_q != OP_MUL);
                    lo_we   = (op_q != OP_MUL);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d   = IDLE;
            hi_we     = 1'b0;
            lo_we     = 1'b0;
            div_start = 1'b0;
            div_annul = (state_q == DIV_BUSY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= bus.op_code;
                a_q  <= bus.op_a;
                b_q  <= bus.op_b;
                if (is_mul_in) cnt_q <= CNT_W'(MUL_LAT);
                // Divide by zero bypasses the div unit with a fixed result.
                if (is_div_in && div_zero) begin
                    hi_q <= bus.op_a;
                    lo_q <= '1;
                end
            end
            if (state_q == MUL_WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1) && !bus.flush) begin
                    hi_q <= bus.mul_result[63:32];
                    lo_q <= bus.mul_result[31:0];
                end
            end
            if (state_q == DIV_BUSY && bus.div_ready && !bus.flush) begin
                hi_q <= bus.div_result[63:32];
                lo_q <= bus.div_result[31:0];
            end
        end
    end

    assign bus.mul_signed = (op_q == OP_MULT);
    assign bus.mul_ina    = a_q;
    assign bus.mul_inb    = b_q;
    assign bus.div_signed = (op_q == OP_DIV);
    assign bus.div_op1    = a_q;
    assign bus.div_op2    = b_q;
    assign bus.div_start  = div_start;
    assign bus.div_annul  = div_annul;
    assign bus.stallreq   = stallreq;
    assign bus.res_valid  = (state_q == DONE);
    assign bus.hi_we      = hi_we;
    assign bus.lo_we      = lo_we;
    assign bus.hi_wdata   = hi_q;
    assign bus.lo_wdata   = lo_q;
    assign bus.gpr_result = lo_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
